// File: rtl/rbe_accum_normquant_streamer_pkg.sv
// Shared widths, configuration record and FSM states for the accumulator
// drain / normalize-quantize streamer.
package rbe_accum_normquant_streamer_pkg;

   localparam int unsigned ADDR_WIDTH   = 5;
   localparam int unsigned DATA_WIDTH   = 32;
   localparam int unsigned NUM_WORDS    = 32;
   localparam int unsigned WIDTH_FACTOR = 4;
   localparam int unsigned SCALE_WIDTH  = 8;
   localparam int unsigned NQ_LANE_BITS = 8;
   localparam int unsigned SHIFT_WIDTH  = 5;
   localparam int unsigned QA_WIDTH     = 4;
   localparam int unsigned COUNT_WIDTH  = ADDR_WIDTH + 1;
   localparam int unsigned PROD_WIDTH   = DATA_WIDTH + SCALE_WIDTH + 1;
   localparam int unsigned OUT_WIDTH    = WIDTH_FACTOR * NQ_LANE_BITS;

   typedef struct packed {
      logic [COUNT_WIDTH-1:0] count;
      logic                   wide;
      logic [SCALE_WIDTH-1:0] scale;
      logic [SHIFT_WIDTH-1:0] shift;
      logic [QA_WIDTH-1:0]    qa;
      logic                   relu;
   } rbe_nq_cfg_t;

   typedef enum logic [1:0] {
      NQ_IDLE,
      NQ_RUN,
      NQ_DONE
   } rbe_nq_state_e;

endpackage

// File: rtl/rbe_accum_normquant_streamer_if.sv
// Valid/ready output stream carrying packed 8-bit lanes plus a lane strobe.
interface rbe_accum_normquant_streamer_if;
   import rbe_accum_normquant_streamer_pkg::*;

   logic                    valid;
   logic                    ready;
   logic [OUT_WIDTH-1:0]    data;
   logic [WIDTH_FACTOR-1:0] strb;

   modport master (output valid, data, strb, input ready);
   modport slave  (input valid, data, strb, output ready);

endinterface

// File: rtl/rbe_accum_normquant_streamer_lane.sv
// One normalization lane: signed scale, round-half-up, arithmetic shift,
// then clip to qa bits (signed or ReLU) on the full-width product.
module rbe_accum_normquant_streamer_lane
   import rbe_accum_normquant_streamer_pkg::*;
(
   input  logic [DATA_WIDTH-1:0]   acc_i,
   input  logic [SCALE_WIDTH-1:0]  scale_i,
   input  logic [SHIFT_WIDTH-1:0]  shift_i,
   input  logic [QA_WIDTH-1:0]     qa_i,
   input  logic                    relu_i,
   output logic [NQ_LANE_BITS-1:0] q_c_o
);

   logic signed [PROD_WIDTH-1:0] acc_s, scale_s, prod, rnd, shifted, hi, lo, clip;

   always_comb begin
      acc_s   = {{(PROD_WIDTH-DATA_WIDTH){acc_i[DATA_WIDTH-1]}}, acc_i};
      scale_s = PROD_WIDTH'(scale_i);
      prod    = acc_s * scale_s;
      rnd     = '0;
      if (shift_i != '0) rnd = PROD_WIDTH'(1) << (shift_i - SHIFT_WIDTH'(1));
      shifted = (prod + rnd) >>> shift_i;
      if (relu_i) begin
         hi = (PROD_WIDTH'(1) << qa_i) - PROD_WIDTH'(1);
         lo = '0;
      end else begin
         hi = (PROD_WIDTH'(1) << (qa_i - QA_WIDTH'(1))) - PROD_WIDTH'(1);
         lo = -(PROD_WIDTH'(1) << (qa_i - QA_WIDTH'(1)));
      end
      // Clip bounds are in-range for 8 bits, so truncation gives the sign/zero extension.
      if (shifted > hi)      clip = hi;
      else if (shifted < lo) clip = lo;
      else                   clip = shifted;
      q_c_o = NQ_LANE_BITS'(clip);
   end

endmodule

// File: rtl/rbe_accum_normquant_streamer.sv
// Drains the accumulator bank through its registered read port, normalizes
// each word and streams packed 8-bit lanes on a valid/ready port.
module rbe_accum_normquant_streamer
   import rbe_accum_normquant_streamer_pkg::*;
(
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 clear_i,
   input  logic                                 start_i,
   input  logic [COUNT_WIDTH-1:0]               cfg_count_i,
   input  logic                                 cfg_wide_i,
   input  logic [SCALE_WIDTH-1:0]               cfg_scale_i,
   input  logic [SHIFT_WIDTH-1:0]               cfg_shift_i,
   input  logic [QA_WIDTH-1:0]                  cfg_qa_i,
   input  logic                                 cfg_relu_i,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 acc_re_o,
   output logic [ADDR_WIDTH-1:0]                acc_raddr_o,
   output logic                                 acc_wide_enable_o,
   input  logic [WIDTH_FACTOR*DATA_WIDTH-1:0]   acc_rdata_wide_i,
   rbe_accum_normquant_streamer_if.master       strm_o
);

   rbe_nq_state_e           state_q, state_d;
   rbe_nq_cfg_t             cfg_q, cfg_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [COUNT_WIDTH-1:0]  issued_q, issued_d;
   logic                    pend_q, pend_d;
   logic [WIDTH_FACTOR-1:0] pend_strb_q, pend_strb_d;
   logic                    valid_q, valid_d;
   logic [OUT_WIDTH-1:0]    data_q, data_d;
   logic [WIDTH_FACTOR-1:0] strb_q, strb_d;
   logic                    busy_q, busy_d, done_q, done_d;

   logic [COUNT_WIDTH-1:0]  left_c, step_c, take_c;
   logic [WIDTH_FACTOR-1:0] issue_strb_c;
   logic                    load_c, re_c;
   logic [NQ_LANE_BITS-1:0] lane_c [WIDTH_FACTOR];

   for (genvar g = 0; g < WIDTH_FACTOR; g++) begin : g_lane
      rbe_accum_normquant_streamer_lane u_lane (
         .acc_i   (acc_rdata_wide_i[g*DATA_WIDTH +: DATA_WIDTH]),
         .scale_i (cfg_q.scale),
         .shift_i (cfg_q.shift),
         .qa_i    (cfg_q.qa),
         .relu_i  (cfg_q.relu),
         .q_c_o   (lane_c[g])
      );
   end

   // Read-issue bookkeeping; the strobe of a group is fixed when it is requested.
   always_comb begin
      left_c = cfg_q.count - issued_q;
      step_c = cfg_q.wide ? COUNT_WIDTH'(WIDTH_FACTOR) : COUNT_WIDTH'(1);
      take_c = (left_c < step_c) ? left_c : step_c;
      load_c = pend_q & (~valid_q | strm_o.ready);
      re_c   = (state_q == NQ_RUN) & (left_c != '0) & (~pend_q | load_c);
      for (int k = 0; k < WIDTH_FACTOR; k++) begin
         issue_strb_c[k] = cfg_q.wide ? (COUNT_WIDTH'(k) < left_c) : (k == 0);
      end
   end

   always_comb begin
      state_d     = state_q;
      cfg_d       = cfg_q;
      addr_d      = addr_q;
      issued_d    = issued_q;
      pend_d      = pend_q;
      pend_strb_d = pend_strb_q;
      valid_d     = valid_q;
      data_d      = data_q;
      strb_d      = strb_q;

      case (state_q)
         NQ_IDLE: begin
            if (start_i) begin
               cfg_d.count = cfg_count_i;
               cfg_d.wide  = cfg_wide_i;
               cfg_d.scale = cfg_scale_i;
               cfg_d.shift = cfg_shift_i;
               cfg_d.qa    = cfg_qa_i;
               cfg_d.relu  = cfg_relu_i;
               addr_d      = '0;
               issued_d    = '0;
               state_d     = (cfg_count_i == '0) ? NQ_DONE : NQ_RUN;
            end
         end
         NQ_RUN: begin
            if (re_c) begin
               addr_d      = addr_q + ADDR_WIDTH'(step_c);
               issued_d    = issued_q + take_c;
               pend_strb_d = issue_strb_c;
               pend_d      = 1'b1;
            end else if (load_c) begin
               pend_d = 1'b0;
            end
            if (load_c) begin
               valid_d = 1'b1;
               strb_d  = pend_strb_q;
               for (int k = 0; k < WIDTH_FACTOR; k++) begin
                  data_d[k*NQ_LANE_BITS +: NQ_LANE_BITS] = pend_strb_q[k] ? lane_c[k] : '0;
               end
            end else if (valid_q & strm_o.ready) begin
               valid_d = 1'b0;
            end
            if ((left_c == '0) & ~pend_q & valid_q & strm_o.ready) state_d = NQ_DONE;
         end
         NQ_DONE: state_d = NQ_IDLE;
         default: state_d = NQ_IDLE;
      endcase

      // Abort drops the stream and any in-flight read without signalling done.
      if (clear_i) begin
         state_d = NQ_IDLE;
         valid_d = 1'b0;
         pend_d  = 1'b0;
      end

      busy_d = (state_d != NQ_IDLE);
      done_d = (state_d == NQ_DONE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= NQ_IDLE;
         cfg_q       <= '0;
         addr_q      <= '0;
         issued_q    <= '0;
         pend_q      <= 1'b0;
         pend_strb_q <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         strb_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_q       <= cfg_d;
         addr_q      <= addr_d;
         issued_q    <= issued_d;
         pend_q      <= pend_d;
         pend_strb_q <= pend_strb_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         strb_q      <= strb_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign acc_re_o          = re_c;
   assign acc_raddr_o       = addr_q;
   assign acc_wide_enable_o = cfg_q.wide;
   assign strm_o.valid      = valid_q;
   assign strm_o.data       = data_q;
   assign strm_o.strb       = strb_q;

endmodule

// File: tb/tb_rbe_accum_normquant_streamer.sv
// Directed bench: bank model, stream monitor with stall-stability checks,
// hand-computed expected beats per scenario.
module tb_rbe_accum_normquant_streamer;
   import rbe_accum_normquant_streamer_pkg::*;

   logic         clk = 1'b0;
   logic         rst, clear, start;
   logic [5:0]   cfg_count;
   logic         cfg_wide, cfg_relu;
   logic [7:0]   cfg_scale;
   logic [4:0]   cfg_shift;
   logic [3:0]   cfg_qa;
   logic         busy, done, acc_re, acc_wide;
   logic [4:0]   raddr;
   logic [127:0] rdata = '0;

   rbe_accum_normquant_streamer_if s_if ();

   rbe_accum_normquant_streamer dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .clear_i           (clear),
      .start_i           (start),
      .cfg_count_i       (cfg_count),
      .cfg_wide_i        (cfg_wide),
      .cfg_scale_i       (cfg_scale),
      .cfg_shift_i       (cfg_shift),
      .cfg_qa_i          (cfg_qa),
      .cfg_relu_i        (cfg_relu),
      .busy_o            (busy),
      .done_o            (done),
      .acc_re_o          (acc_re),
      .acc_raddr_o       (raddr),
      .acc_wide_enable_o (acc_wide),
      .acc_rdata_wide_i  (rdata),
      .strm_o            (s_if)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bank: registered read port, data held until the next read enable.
   logic [31:0] mem [32];
   always @(posedge clk) begin
      if (acc_re) begin
         for (int k = 0; k < 4; k++) begin
            if (acc_wide || k == 0) rdata[k*32 +: 32] <= mem[raddr + 5'(k)];
            else                    rdata[k*32 +: 32] <= 32'hDEAD_BEEF;
         end
      end
   end

   int          cyc = 0, done_cnt = 0, re_cnt = 0, vld_cnt = 0;
   logic [31:0] got_d[$];
   logic [3:0]  got_s[$];
   int          got_c[$];
   logic [4:0]  re_addr[$];
   logic [31:0] exp_d[$];
   logic [3:0]  exp_s[$];
   logic        stall_q = 1'b0;
   logic [31:0] stall_d;
   logic [3:0]  stall_s;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (acc_re) begin
         re_cnt <= re_cnt + 1;
         re_addr.push_back(raddr);
      end
      if (s_if.valid) vld_cnt <= vld_cnt + 1;
      if (stall_q) begin
         chk("stall_valid", 64'(s_if.valid), 64'd1);
         chk("stall_hold", 64'({s_if.strb, s_if.data}), 64'({stall_s, stall_d}));
      end
      if (s_if.valid && s_if.ready) begin
         got_d.push_back(s_if.data);
         got_s.push_back(s_if.strb);
         got_c.push_back(cyc);
      end
      stall_q <= s_if.valid && !s_if.ready && !clear && !rst;
      stall_d <= s_if.data;
      stall_s <= s_if.strb;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [5:0] cnt, input logic wide, input logic [7:0] sc,
                     input logic [4:0] sh, input logic [3:0] qa, input logic relu);
      cfg_count = cnt; cfg_wide = wide; cfg_scale = sc;
      cfg_shift = sh;  cfg_qa = qa;     cfg_relu = relu;
      start = 1'b1;
      step();
      start = 1'b0;
      // Scramble cfg after start; the drain must keep the sampled values.
      cfg_count = 6'd17; cfg_wide = ~wide; cfg_scale = 8'd77;
      cfg_shift = 5'd9;  cfg_qa = 4'd3;    cfg_relu = ~relu;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int d0 = done_cnt;
      int i = 0;
      while (done_cnt == d0 && i < bound) begin
         step();
         i++;
      end
      chk(tag, 64'(done_cnt - d0), 64'd1);
      step();
   endtask

   task automatic check_beats(input string tag);
      chk({tag, "_nbeats"}, 64'(got_d.size()), 64'(exp_d.size()));
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         chk({tag, "_data"}, 64'(got_d[i]), 64'(exp_d[i]));
         chk({tag, "_strb"}, 64'(got_s[i]), 64'(exp_s[i]));
      end
      got_d.delete(); got_s.delete(); got_c.delete();
      exp_d.delete(); exp_s.delete();
   endtask

   task automatic flush();
      got_d.delete(); got_s.delete(); got_c.delete(); re_addr.delete();
      exp_d.delete(); exp_s.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int          d0, r0, v0;
      logic [31:0] w;

      rst = 1'b1; clear = 1'b0; start = 1'b0;
      cfg_count = '0; cfg_wide = 1'b0; cfg_scale = '0;
      cfg_shift = '0; cfg_qa = '0;     cfg_relu = 1'b0;
      s_if.ready = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      repeat (3) step();
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_re",    64'(acc_re), 64'd0);
      chk("rst_raddr", 64'(raddr), 64'd0);
      chk("rst_wide",  64'(acc_wide), 64'd0);
      chk("rst_valid", 64'(s_if.valid), 64'd0);
      chk("rst_out",   64'({s_if.strb, s_if.data}), 64'd0);
      rst = 1'b0;
      step();

      // Narrow: 100*3 -> 75, -7*3 -> -5, 5*3 -> 4 (shift 2, round half up)
      flush();
      mem[0] = 32'd100; mem[1] = 32'hFFFF_FFF9; mem[2] = 32'd5;
      s_if.ready = 1'b1;
      go(6'd3, 1'b0, 8'd3, 5'd2, 4'd8, 1'b0);
      wait_done("t1_done", 30);
      if (got_c.size() == 3) chk("t1_consec", 64'(got_c[2] - got_c[0]), 64'd2);
      else                   chk("t1_consec", 64'(got_c.size()), 64'd3);
      exp_d = '{32'h0000_004B, 32'h0000_00FB, 32'h0000_0004};
      exp_s = '{4'b0001, 4'b0001, 4'b0001};
      check_beats("t1");
      chk("t1_idle", 64'(busy), 64'd0);

      // Wide ReLU qa=4: {-3,20,7,0} -> {0,15,7,0}; {15,16} -> {15,15} partial
      flush();
      mem[0] = 32'hFFFF_FFFD; mem[1] = 32'd20; mem[2] = 32'd7; mem[3] = 32'd0;
      mem[4] = 32'd15; mem[5] = 32'd16; mem[6] = 32'd99; mem[7] = 32'd99;
      go(6'd6, 1'b1, 8'd1, 5'd0, 4'd4, 1'b1);
      wait_done("t2_done", 30);
      exp_d = '{32'h0007_0F00, 32'h0000_0F0F};
      exp_s = '{4'b1111, 4'b0011};
      check_beats("t2");
      chk("t2_nreads", 64'(re_addr.size()), 64'd2);
      if (re_addr.size() == 2) begin
         chk("t2_addr0", 64'(re_addr[0]), 64'd0);
         chk("t2_addr1", 64'(re_addr[1]), 64'd4);
      end

      // Backpressure: full bank wide, ready pattern 1-0-0-1, identity transform
      flush();
      for (int i = 0; i < 32; i++) mem[i] = 32'(i) - 32'd10;
      go(6'd32, 1'b1, 8'd1, 5'd0, 4'd8, 1'b0);
      d0 = done_cnt;
      for (int i = 0; i < 300 && done_cnt == d0; i++) begin
         s_if.ready = (i % 4 == 0) || (i % 4 == 3);
         step();
      end
      chk("t3_done", 64'(done_cnt - d0), 64'd1);
      s_if.ready = 1'b1;
      step();
      for (int b = 0; b < 8; b++) begin
         for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(4*b + k - 10);
         exp_d.push_back(w);
         exp_s.push_back(4'b1111);
      end
      check_beats("t3");
      chk("t3_nreads", 64'(re_addr.size()), 64'd8);
      for (int b = 0; b < 8 && b < re_addr.size(); b++) chk("t3_addr", 64'(re_addr[b]), 64'(4*b));

      // Saturation: max*255 -> 127, min*255 -> -128, -1*255 -> -128
      flush();
      mem[0] = 32'h7FFF_FFFF; mem[1] = 32'h8000_0000; mem[2] = 32'hFFFF_FFFF;
      go(6'd3, 1'b0, 8'd255, 5'd0, 4'd8, 1'b0);
      wait_done("t4_done", 30);
      exp_d = '{32'h0000_007F, 32'h0000_0080, 32'h0000_0080};
      exp_s = '{4'b0001, 4'b0001, 4'b0001};
      check_beats("t4");

      // ReLU qa=2, shift 4, scale 10: 7 -> 3 (clip), -7 -> 0, 5 -> 3
      flush();
      mem[0] = 32'd7; mem[1] = 32'hFFFF_FFF9; mem[2] = 32'd5;
      go(6'd3, 1'b0, 8'd10, 5'd4, 4'd2, 1'b1);
      wait_done("t4b_done", 30);
      exp_d = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0003};
      exp_s = '{4'b0001, 4'b0001, 4'b0001};
      check_beats("t4b");

      // count=0: done without any read or beat
      flush();
      r0 = re_cnt; v0 = vld_cnt;
      go(6'd0, 1'b1, 8'd1, 5'd0, 4'd8, 1'b0);
      wait_done("t5_done", 4);
      chk("t5_reads", 64'(re_cnt - r0), 64'd0);
      chk("t5_valid", 64'(vld_cnt - v0), 64'd0);

      // Clear while stalled, then restart from address 0
      flush();
      for (int i = 0; i < 32; i++) mem[i] = 32'(i) - 32'd10;
      s_if.ready = 1'b0;
      go(6'd32, 1'b1, 8'd1, 5'd0, 4'd8, 1'b0);
      for (int i = 0; i < 20 && !s_if.valid; i++) step();
      chk("t6_valid_up", 64'(s_if.valid), 64'd1);
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("t6_valid_clr", 64'(s_if.valid), 64'd0);
      chk("t6_busy_clr", 64'(busy), 64'd0);
      d0 = done_cnt;
      repeat (5) step();
      chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
      flush();
      s_if.ready = 1'b1;
      go(6'd8, 1'b1, 8'd1, 5'd0, 4'd8, 1'b0);
      wait_done("t6_done", 30);
      exp_d = '{32'hF9F8_F7F6, 32'hFDFC_FBFA};
      exp_s = '{4'b1111, 4'b1111};
      check_beats("t6");
      if (re_addr.size() == 2) chk("t6_addr0", 64'(re_addr[0]), 64'd0);
      else                     chk("t6_nreads", 64'(re_addr.size()), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
